// File: rtl/crypto_tagger_pkg.sv
// Shared constants, bus word layout and FSM encoding for the crypto tagger.
// The crypto stage keys off the same tag ctrl value and header word positions.
package crypto_tagger_pkg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 8;

    localparam logic [7:0]  CRYPTO_TAG_CTRL = 8'hFB;
    localparam logic [15:0] IP_ETHERTYPE    = 16'h0800;

    localparam int ETYPE_WORD     = 2;
    localparam int DST_IP_WORD_HI = 4;
    localparam int DST_IP_WORD_LO = 5;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } bus_word_t;

    typedef enum logic [3:0] {
        COLLECT  = 4'b0001,
        EMIT_TAG = 4'b0010,
        EMIT_BUF = 4'b0100,
        PASS     = 4'b1000
    } tag_state_e;

    localparam int S_COLLECT  = 0;
    localparam int S_EMIT_TAG = 1;
    localparam int S_EMIT_BUF = 2;
    localparam int S_PASS     = 3;

    function automatic logic ip_match(
        input logic [31:0] dst,
        input logic [31:0] ip,
        input logic [31:0] mask
    );
        return (dst & mask) == (ip & mask);
    endfunction

endpackage

// File: rtl/crypto_hdr_buf.sv
// Header buffer: holds the leading words of a packet until the tag decision.
// Pointers carry one extra bit so full and empty are distinguishable.
module crypto_hdr_buf
    import crypto_tagger_pkg::*;
#(
    parameter int DEPTH_BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                wr_en,
    input  bus_word_t           wr_word,
    input  logic                rd_en,
    output bus_word_t           rd_word,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_BITS:0] count
);

    localparam int DEPTH = 2 ** DEPTH_BITS;

    bus_word_t mem [DEPTH];

    logic [DEPTH_BITS:0] wr_ptr;
    logic [DEPTH_BITS:0] rd_ptr;
    logic                do_wr;
    logic                do_rd;

    assign count = wr_ptr - rd_ptr;
    assign full  = count == (DEPTH_BITS + 1)'(DEPTH);
    assign empty = count == '0;
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign rd_word = mem[rd_ptr[DEPTH_BITS-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[DEPTH_BITS-1:0]] <= wr_word;
    end

endmodule

// File: rtl/crypto_tagger.sv
// Crypto tagger: classifies packets by IPv4 destination and prepends a tag word
// whose data bit 0 tells the crypto stage whether to act on the packet.
module crypto_tagger #(
    parameter int         DATA_WIDTH      = 64,
    parameter int         CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int         BUF_DEPTH_BITS  = 3,
    parameter logic [7:0] CRYPTO_TAG_CTRL = crypto_tagger_pkg::CRYPTO_TAG_CTRL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic [31:0]           match_ip,
    input  logic [31:0]           match_mask,
    output logic [31:0]           tag_count
);

    import crypto_tagger_pkg::bus_word_t;
    import crypto_tagger_pkg::tag_state_e;
    import crypto_tagger_pkg::COLLECT;
    import crypto_tagger_pkg::EMIT_TAG;
    import crypto_tagger_pkg::EMIT_BUF;
    import crypto_tagger_pkg::PASS;
    import crypto_tagger_pkg::S_COLLECT;
    import crypto_tagger_pkg::S_EMIT_TAG;
    import crypto_tagger_pkg::S_EMIT_BUF;
    import crypto_tagger_pkg::S_PASS;
    import crypto_tagger_pkg::IP_ETHERTYPE;
    import crypto_tagger_pkg::ETYPE_WORD;
    import crypto_tagger_pkg::DST_IP_WORD_HI;
    import crypto_tagger_pkg::DST_IP_WORD_LO;
    import crypto_tagger_pkg::ip_match;

    localparam int CNT_W = BUF_DEPTH_BITS + 1;
    localparam logic [CNT_W-1:0] BUF_LAST =
        CNT_W'(2 ** BUF_DEPTH_BITS - 1);

    // Input fallthrough FIFO, depth 4
    bus_word_t   fifo_mem [4];
    logic [1:0]  fifo_wr_ptr;
    logic [1:0]  fifo_rd_ptr;
    logic [2:0]  fifo_count;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_nearly_full;
    bus_word_t   head;

    assign fifo_empty       = fifo_count == 3'd0;
    assign fifo_full        = fifo_count == 3'd4;
    assign fifo_nearly_full = fifo_count >= 3'd3;
    assign fifo_push        = in_wr && !fifo_full;
    assign head             = fifo_mem[fifo_rd_ptr];
    assign in_rdy           = !fifo_nearly_full && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
        end else begin
            if (fifo_push) fifo_wr_ptr <= fifo_wr_ptr + 1'b1;
            if (fifo_pop)  fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
            fifo_count <= fifo_count + 3'(fifo_push) - 3'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[fifo_wr_ptr] <= '{ctrl: in_ctrl, data: in_data};
        end
    end

    // Header buffer
    logic             buf_wr;
    logic             buf_rd;
    logic             buf_flush;
    logic             buf_full;
    logic             buf_empty;
    logic [CNT_W-1:0] buf_count;
    bus_word_t        buf_word;

    crypto_hdr_buf #(
        .DEPTH_BITS(BUF_DEPTH_BITS)
    ) u_hdr_buf (
        .clk    (clk),
        .reset  (reset),
        .flush  (buf_flush),
        .wr_en  (buf_wr),
        .wr_word(head),
        .rd_en  (buf_rd),
        .rd_word(buf_word),
        .full   (buf_full),
        .empty  (buf_empty),
        .count  (buf_count)
    );

    tag_state_e  state;
    tag_state_e  state_d;
    logic [3:0]  word_idx;
    logic [3:0]  idx_next;
    logic        flag;
    logic [15:0] etype;
    logic [15:0] dst_hi;
    logic        buf_has_eop;

    logic        head_is_data;
    logic        head_is_eop;
    logic        at_dst_lo;
    logic [31:0] dst_ip;
    logic        ip_hit;

    assign head_is_data = head.ctrl == '0;
    assign head_is_eop  = !head_is_data && word_idx != 4'd0;
    assign idx_next     = word_idx + 4'd1;
    assign at_dst_lo    = head_is_data &&
                          idx_next == 4'(DST_IP_WORD_LO);
    assign dst_ip       = {dst_hi, head.data[63:48]};
    assign ip_hit       = etype == IP_ETHERTYPE &&
                          ip_match(dst_ip, match_ip, match_mask);

    logic      out_vld;
    logic      pkt_done;
    bus_word_t out_word;

    always_comb begin
        state_d   = state;
        fifo_pop  = 1'b0;
        buf_wr    = 1'b0;
        buf_rd    = 1'b0;
        buf_flush = 1'b0;
        out_vld   = 1'b0;
        pkt_done  = 1'b0;
        out_word  = head;
        unique case (1'b1)
            state[S_COLLECT]: begin
                if (!fifo_empty && !buf_full) begin
                    fifo_pop = 1'b1;
                    buf_wr   = 1'b1;
                    if (at_dst_lo || head_is_eop ||
                        buf_count == BUF_LAST) begin
                        state_d = EMIT_TAG;
                    end
                end
            end
            state[S_EMIT_TAG]: begin
                out_vld       = 1'b1;
                out_word.ctrl = CRYPTO_TAG_CTRL;
                out_word.data = {63'b0, flag};
                if (out_rdy) state_d = EMIT_BUF;
            end
            state[S_EMIT_BUF]: begin
                out_vld  = !buf_empty;
                out_word = buf_word;
                if (out_rdy && !buf_empty) begin
                    buf_rd = 1'b1;
                    if (buf_count == CNT_W'(1)) begin
                        if (buf_has_eop) begin
                            state_d   = COLLECT;
                            pkt_done  = 1'b1;
                            buf_flush = 1'b1;
                        end else begin
                            state_d = PASS;
                        end
                    end
                end
            end
            state[S_PASS]: begin
                out_vld = !fifo_empty;
                if (!fifo_empty && out_rdy) begin
                    fifo_pop = 1'b1;
                    if (!head_is_data) begin
                        state_d  = COLLECT;
                        pkt_done = 1'b1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign out_wr   = out_vld && out_rdy && !reset;
    assign out_data = out_word.data;
    assign out_ctrl = out_word.ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= COLLECT;
            word_idx    <= '0;
            flag        <= 1'b0;
            etype       <= '0;
            dst_hi      <= '0;
            buf_has_eop <= 1'b0;
            tag_count   <= '0;
        end else begin
            state <= state_d;
            if (pkt_done) begin
                word_idx    <= '0;
                flag        <= 1'b0;
                buf_has_eop <= 1'b0;
            end else if (state[S_COLLECT] && fifo_pop) begin
                if (head_is_data) begin
                    word_idx <= idx_next;
                    if (idx_next == 4'(ETYPE_WORD))
                        etype <= head.data[31:16];
                    if (idx_next == 4'(DST_IP_WORD_HI))
                        dst_hi <= head.data[15:0];
                    // match inputs are sampled only here
                    if (at_dst_lo) flag <= ip_hit;
                end
                if (head_is_eop) buf_has_eop <= 1'b1;
            end
            if (state[S_EMIT_TAG] && out_rdy && flag) begin
                tag_count <= tag_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_crypto_tagger.sv
// Directed bench for crypto_tagger: tagging, pass-through, short packets,
// backpressure, back-to-back packets and reset mid-packet.
`timescale 1ns/1ps
module tb_crypto_tagger;
    import crypto_tagger_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic [31:0] match_ip;
    logic [31:0] match_mask;
    logic [31:0] tag_count;

    always #5 clk = ~clk;

    crypto_tagger dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_wr     (in_wr),
        .in_rdy    (in_rdy),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_wr    (out_wr),
        .out_rdy   (out_rdy),
        .match_ip  (match_ip),
        .match_mask(match_mask),
        .tag_count (tag_count)
    );

    logic [71:0] pkt[$];
    logic [71:0] expq[$];
    logic [71:0] outq[$];
    int          tests = 0;
    int          fails = 0;
    int          rdy_viol = 0;
    bit          rand_rdy = 1'b0;
    logic [31:0] exp_cnt = 32'd0;

    always @(negedge clk) begin
        if (!reset) begin
            if (out_wr) outq.push_back({out_ctrl, out_data});
            if (out_wr && !out_rdy) rdy_viol++;
        end
    end

    task automatic chk(input string name, input logic [71:0] got,
                       input logic [71:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic make_pkt(input int ndata, input logic [15:0] et,
                            input logic [31:0] ip, input logic [7:0] seed,
                            input logic flag);
        logic [63:0] d;
        logic [7:0]  c;
        expq.push_back({8'hFB, 63'b0, flag});
        pkt.push_back({8'hFF, 56'h0, seed});
        expq.push_back({8'hFF, 56'h0, seed});
        for (int i = 1; i <= ndata; i++) begin
            d = {seed, 8'(i), 16'h5A5A, 32'(i) * 32'h01010101};
            if (i == 2) d[31:16] = et;
            if (i == 4) d[15:0] = ip[31:16];
            if (i == 5) d[63:48] = ip[15:0];
            c = (i == ndata) ? 8'h80 : 8'h00;
            pkt.push_back({c, d});
            expq.push_back({c, d});
        end
    endtask

    task automatic send_n(input int n);
        int i = 0;
        int budget = 0;
        while (i < n && budget < 5000) begin
            step();
            budget++;
            if (in_rdy) begin
                {in_ctrl, in_data} = pkt[i];
                in_wr = 1'b1;
                i++;
            end else begin
                in_wr = 1'b0;
            end
        end
        step();
        in_wr = 1'b0;
        chk("send_done", 72'(i), 72'(n));
        pkt.delete();
    endtask

    task automatic send_all();
        send_n(pkt.size());
    endtask

    task automatic drain(input string name);
        int b = 0;
        int n;
        while (outq.size() < expq.size() && b < 3000) begin
            step();
            b++;
        end
        repeat (5) step();
        chk({name, "_len"}, 72'(outq.size()), 72'(expq.size()));
        n = (outq.size() < expq.size()) ? outq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d]", name, i), outq[i], expq[i]);
        end
        outq.delete();
        expq.delete();
    endtask

    initial begin
        reset      = 1'b1;
        in_wr      = 1'b0;
        in_data    = '0;
        in_ctrl    = '0;
        out_rdy    = 1'b1;
        match_ip   = 32'hC0A8A300;
        match_mask = 32'hFFFFFF00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_wr", 72'(out_wr), 72'(0));
        chk("rst_in_rdy", 72'(in_rdy), 72'(0));
        reset = 1'b0;
        step();
        chk("rst_tag_count", 72'(tag_count), 72'(0));
        chk("idle_in_rdy", 72'(in_rdy), 72'(1));
        chk("idle_out_wr", 72'(out_wr), 72'(0));

        // 192.168.163.7 inside the programmed /24
        make_pkt(8, 16'h0800, 32'hC0A8A307, 8'h01, 1'b1);
        send_all();
        drain("t1");
        exp_cnt = 32'd1;
        chk("t1_count", 72'(tag_count), 72'(exp_cnt));

        make_pkt(8, 16'h0800, 32'h0A000001, 8'h02, 1'b0);
        send_all();
        drain("t2_ip");
        make_pkt(8, 16'h0806, 32'hC0A8A307, 8'h03, 1'b0);
        send_all();
        drain("t2_arp");
        chk("t2_count", 72'(tag_count), 72'(exp_cnt));

        make_pkt(3, 16'h0800, 32'hC0A8A307, 8'h04, 1'b0);
        send_all();
        drain("t3");
        chk("t3_state", 72'(dut.state), 72'(COLLECT));

        rand_rdy = 1'b1;
        make_pkt(63, 16'h0800, 32'hC0A8A3FE, 8'h05, 1'b1);
        send_all();
        drain("t4");
        rand_rdy = 1'b0;
        exp_cnt = 32'd2;
        chk("t4_count", 72'(tag_count), 72'(exp_cnt));
        chk("t4_rdy_viol", 72'(rdy_viol), 72'(0));

        make_pkt(8, 16'h0800, 32'hC0A8A311, 8'h06, 1'b1);
        make_pkt(10, 16'h0800, 32'h0A0A0A0A, 8'h07, 1'b0);
        make_pkt(6, 16'h0800, 32'hC0A8A380, 8'h08, 1'b1);
        send_all();
        drain("t5");
        exp_cnt = 32'd4;
        chk("t5_count", 72'(tag_count), 72'(exp_cnt));

        // zero mask tags any IPv4 destination
        match_mask = 32'h0;
        make_pkt(6, 16'h0800, 32'h0A000001, 8'h09, 1'b1);
        send_all();
        drain("t5_mask0");
        match_mask = 32'hFFFFFF00;
        exp_cnt = 32'd5;
        chk("t5_mask0_count", 72'(tag_count), 72'(exp_cnt));

        make_pkt(19, 16'h0800, 32'hC0A8A301, 8'h0A, 1'b1);
        send_n(14);
        chk("t6_pass_active", 72'(out_wr), 72'(1));
        reset = 1'b1;
        #1;
        chk("t6_rst_out_wr", 72'(out_wr), 72'(0));
        chk("t6_rst_in_rdy", 72'(in_rdy), 72'(0));
        repeat (2) step();
        reset = 1'b0;
        step();
        outq.delete();
        expq.delete();
        pkt.delete();
        chk("t6_count_clr", 72'(tag_count), 72'(0));
        make_pkt(8, 16'h0800, 32'hC0A8A307, 8'h0B, 1'b1);
        send_all();
        drain("t6_fresh");
        chk("t6_count", 72'(tag_count), 72'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
